dshot_rx: RTL
=============

// Module: dshot_rx
// PURPOSE
//  Decodes a DShot serial throttle stream from the flight controller pin into an 8-bit speed.
//  Sits directly upstream of the servo-PWM generator.
//  Drives its targetSpeed input and its enable input (armed).
//  Validates each frame's CRC, separates throttle from special commands, and applies a link-loss failsafe.
// PARAMETERS
//  CLK_HZ        16000000  system clock frequency
//  DSHOT_KBPS    150       DShot bit rate in kbit/s
//  FAILSAFE_CYC  1600000   clocks without a valid frame before disarm (100 ms)
//  Derived: BIT_CYC = CLK_HZ/(DSHOT_KBPS*1000) (106); THRESH = BIT_CYC/2 (53);
//           MIN_HIGH = BIT_CYC/8 (13); GAP_CYC = 2*BIT_CYC (212)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   synchronous reset, active low
//  dshotPin      in   1   raw asynchronous DShot line
//  targetSpeed   out  8   decoded speed, held between frames
//  armed         out  1   motor enable
//  frameValid    out  1   1-cycle pulse: good throttle frame accepted
//  cmdValid      out  1   1-cycle pulse: good command frame (value 1..47) accepted
//  cmd           out  6   command number, valid with cmdValid
//  telemReq      out  1   telemetry bit of the last accepted frame
//  crcErr        out  1   1-cycle pulse: 16 bits received, CRC mismatch
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active low.
//  - Reset values: targetSpeed=0, armed=0, telemReq=0, cmd=0, all pulses=0. State=IDLE, counters=0.
//  - Input path: 2-flop synchronizer, then a registered copy for edge detect.
//    - All timing below refers to the synchronized signal.
//  - FSM states:
//    - IDLE: waits for a rising edge; clears the bit count; goes to HIGH.
//    - HIGH: counts high clocks (hiCnt saturates at 255).
//      - On the falling edge: if hiCnt<MIN_HIGH, abort to IDLE with no pulse (glitch).
//      - Otherwise shift in bit = (hiCnt>=THRESH), MSB first.
//      - On the 16th bit go to CHECK; else go to LOW.
//    - LOW: counts low clocks.
//      - A rising edge goes to HIGH (next bit).
//      - If the low count reaches GAP_CYC, the partial frame is discarded -> IDLE, no pulse.
//    - CHECK: single cycle.
//      - Frame layout: f[15:5]=throttle, f[4]=telem, f[3:0]=crc.
//      - Expected crc = (v^(v>>4)^(v>>8))&0xF, where v=f[15:4].
//      - Go to IDLE.
//  - CHECK results, registered, visible the cycle after CHECK (3 clocks after the synchronized 16th falling edge):
//    - CRC bad: crcErr=1. Outputs and failsafe timer unchanged.
//    - throttle==0: targetSpeed=0, armed=0, frameValid=1.
//    - throttle 1..47: cmdValid=1, cmd=throttle[5:0]. targetSpeed and armed unchanged.
//    - throttle>=48: targetSpeed=throttle[10:3], armed=1, frameValid=1.
//    - Any good frame: telemReq=f[4], and the failsafe timer is cleared.
//  - Failsafe timer counts every clock while armed=1.
//    - At FAILSAFE_CYC: armed=0 and targetSpeed=0.
//    - It stays there until the next good throttle>=48 frame.
//    - Simultaneous expiry and good frame: the frame wins.
//  - A rising edge arriving while in CHECK is not lost.
//    - CHECK branches to HIGH instead of IDLE, with the bit count cleared.
//  - rst_n low mid-frame: the partial frame is dropped and all outputs return to reset values.
// CONFIGURATION
//  - DSHOT_BIDIR_EN defined (bidirectional / inverted DShot):
//    - The synchronized input is inverted (line idles high).
//    - Expected crc is the bitwise inverse of the formula above.
//  - DSHOT_BIDIR_EN undefined: standard non-inverted line, normal CRC.
// TESTING
//  - Send frame 0x830B (throttle 1048, telem 0) -> frameValid pulse, targetSpeed=131, armed=1, crcErr=0.
//  - Send 0x830A -> crcErr pulse; targetSpeed/armed keep their previous values; no frameValid.
//  - Send 0x0145 (command 10) -> cmdValid pulse, cmd=10, targetSpeed unchanged. Then send 0x0000 -> targetSpeed=0, armed=0.
//  - Arm, then run FAILSAFE_CYC=1000 idle clocks -> armed=0 and targetSpeed=0 at cycle 1000; no crcErr.
//  - Send 8 bits, hold low 212 clocks, then a full 0x830B -> first fragment silent; second frame decodes to 131.
//  - Assert rst_n=0 at bit 9 of a frame, release, send 0x830B -> clean decode. With DSHOT_BIDIR_EN, inverted line + frame 0x8304 -> 131.

Source files
------------

// File: rtl/dshot_rx.sv
// rtl/dshot_rx.sv - DShot frame receiver with CRC check, command split and link-loss failsafe
//
// Decodes a DShot pulse-width serial stream into an 8-bit speed and an arm
// enable for the downstream servo-PWM generator. Each 16-bit frame is CRC
// checked, zero throttle disarms, values 1..47 are reported as commands,
// and a failsafe timer disarms if no good frame arrives in time.
//
// Optional feature macro: DSHOT_BIDIR_EN
//   defined   : inverted line (idles high) and inverted CRC nibble
//   undefined : standard non-inverted line, normal CRC
//
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  synchronous reset, active low
//   dshotPin     in   1  raw asynchronous DShot line
//   targetSpeed  out  8  decoded speed, held between frames
//   armed        out  1  motor enable
//   frameValid   out  1  1-cycle pulse, good throttle frame accepted
//   cmdValid     out  1  1-cycle pulse, good command frame (1..47) accepted
//   cmd          out  6  command number, valid with cmdValid
//   telemReq     out  1  telemetry bit of the last accepted frame
//   crcErr       out  1  1-cycle pulse, 16 bits received with CRC mismatch
module dshot_rx #(
    parameter int unsigned CLK_HZ       = 16000000,
    parameter int unsigned DSHOT_KBPS   = 150,
    parameter int unsigned FAILSAFE_CYC = 1600000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dshotPin,
    output logic [7:0] targetSpeed,
    output logic       armed,
    output logic       frameValid,
    output logic       cmdValid,
    output logic [5:0] cmd,
    output logic       telemReq,
    output logic       crcErr
);
    localparam int unsigned BIT_CYC  = CLK_HZ / (DSHOT_KBPS * 1000);
    localparam int unsigned THRESH   = BIT_CYC / 2;
    localparam int unsigned MIN_HIGH = BIT_CYC / 8;
    localparam int unsigned GAP_CYC  = 2 * BIT_CYC;
    localparam int unsigned LO_W     = $clog2(GAP_CYC + 1);
    localparam int unsigned FS_W     = $clog2(FAILSAFE_CYC + 1);

    localparam logic [7:0]      THRESH_V = 8'(THRESH);
    localparam logic [7:0]      MIN_V    = 8'(MIN_HIGH);
    localparam logic [LO_W-1:0] GAP_V    = LO_W'(GAP_CYC);
    localparam logic [FS_W-1:0] FS_LAST  = FS_W'(FAILSAFE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_CHECK
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              prev_q, prev_d;
    logic [7:0]        hi_cnt_q, hi_cnt_d;
    logic [LO_W-1:0]   lo_cnt_q, lo_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       shift_q, shift_d;
    logic [FS_W-1:0]   fs_cnt_q, fs_cnt_d;
    logic [7:0]        speed_q, speed_d;
    logic              armed_q, armed_d;
    logic              frame_valid_q, frame_valid_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [5:0]        cmd_q, cmd_d;
    logic              telem_q, telem_d;
    logic              crc_err_q, crc_err_d;

    logic              line_s;
    logic              rise;
    logic              fall;
    logic [11:0]       crc_v;
    logic [3:0]        crc_calc;
    logic [3:0]        crc_exp;
    logic              crc_ok;
    logic [10:0]       throttle;

    // v ^ (v>>4) ^ (v>>8) masked to a nibble is the XOR of the three nibbles of v.
    assign crc_v    = shift_q[15:4];
    assign crc_calc = crc_v[3:0] ^ crc_v[7:4] ^ crc_v[11:8];
    assign throttle = shift_q[15:5];

`ifdef DSHOT_BIDIR_EN
    // Inverted line idles high; the synchronizer resets to the idle level so
    // no false rising edge is seen when reset is released.
    localparam logic IDLE_LVL = 1'b1;
    assign line_s  = ~sync2_q;
    assign crc_exp = ~crc_calc;
`else
    localparam logic IDLE_LVL = 1'b0;
    assign line_s  = sync2_q;
    assign crc_exp = crc_calc;
`endif

    assign crc_ok = (shift_q[3:0] == crc_exp);
    assign rise   = line_s & ~prev_q;
    assign fall   = ~line_s & prev_q;

    // Input synchronizer and edge-detect copy.
    always_comb begin
        sync1_d = dshotPin;
        sync2_d = sync1_q;
        prev_d  = line_s;
    end

    // Bit-level receive FSM.
    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        lo_cnt_d  = lo_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d   = S_HIGH;
                    bit_cnt_d = '0;
                    hi_cnt_d  = 8'd1;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    if (hi_cnt_q < MIN_V) begin
                        state_d = S_IDLE;
                    end else begin
                        shift_d = {shift_q[14:0], (hi_cnt_q >= THRESH_V)};
                        if (bit_cnt_q == 4'd15) begin
                            state_d = S_CHECK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            lo_cnt_d  = LO_W'(1);
                            state_d   = S_LOW;
                        end
                    end
                end else if (hi_cnt_q != 8'hFF) begin
                    hi_cnt_d = hi_cnt_q + 8'd1;
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_d  = S_HIGH;
                    hi_cnt_d = 8'd1;
                end else begin
                    lo_cnt_d = lo_cnt_q + LO_W'(1);
                    if (lo_cnt_d >= GAP_V) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CHECK: begin
                // A new frame may start right behind the last bit; catch its edge here.
                if (rise) begin
                    state_d   = S_HIGH;
                    bit_cnt_d = '0;
                    hi_cnt_d  = 8'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame result and failsafe handling.
    always_comb begin
        speed_d       = speed_q;
        armed_d       = armed_q;
        cmd_d         = cmd_q;
        telem_d       = telem_q;
        fs_cnt_d      = fs_cnt_q;
        frame_valid_d = 1'b0;
        cmd_valid_d   = 1'b0;
        crc_err_d     = 1'b0;

        if (armed_q) begin
            if (fs_cnt_q == FS_LAST) begin
                armed_d  = 1'b0;
                speed_d  = '0;
                fs_cnt_d = '0;
            end else begin
                fs_cnt_d = fs_cnt_q + FS_W'(1);
            end
        end

        // Frame results override any same-cycle failsafe expiry.
        if (state_q == S_CHECK) begin
            if (!crc_ok) begin
                crc_err_d = 1'b1;
            end else begin
                telem_d  = shift_q[4];
                fs_cnt_d = '0;
                if (throttle == 11'd0) begin
                    speed_d       = '0;
                    armed_d       = 1'b0;
                    frame_valid_d = 1'b1;
                end else if (throttle < 11'd48) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = throttle[5:0];
                    speed_d     = speed_q;
                    armed_d     = armed_q;
                end else begin
                    speed_d       = throttle[10:3];
                    armed_d       = 1'b1;
                    frame_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sync1_q       <= IDLE_LVL;
            sync2_q       <= IDLE_LVL;
            prev_q        <= 1'b0;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            fs_cnt_q      <= '0;
            speed_q       <= '0;
            armed_q       <= 1'b0;
            frame_valid_q <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= '0;
            telem_q       <= 1'b0;
            crc_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            fs_cnt_q      <= fs_cnt_d;
            speed_q       <= speed_d;
            armed_q       <= armed_d;
            frame_valid_q <= frame_valid_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_q         <= cmd_d;
            telem_q       <= telem_d;
            crc_err_q     <= crc_err_d;
        end
    end

    assign targetSpeed = speed_q;
    assign armed       = armed_q;
    assign frameValid  = frame_valid_q;
    assign cmdValid    = cmd_valid_q;
    assign cmd         = cmd_q;
    assign telemReq    = telem_q;
    assign crcErr      = crc_err_q;

endmodule
